// File: rtl/hi_lo_multiply_divide_unit_if.sv
// Issue, direct-write and result signals between decode/execute and the HI/LO
// multiply/divide unit.
interface hi_lo_multiply_divide_unit_if;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        HI_register_write;
  logic        LO_register_write;
  logic [31:0] write_data;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  modport master (
    output start, funct, operand_A, operand_B,
    output HI_register_write, LO_register_write, write_data,
    input  HI, LO, busy, done
  );

  modport slave (
    input  start, funct, operand_A, operand_B,
    input  HI_register_write, LO_register_write, write_data,
    output HI, LO, busy, done
  );
endinterface

// File: rtl/hi_lo_multiply_divide_unit.sv
// HI/LO owner: single-cycle mult/multu, 32-iteration restoring div/divu,
// MTHI/MTLO direct writes, and a registered busy/done pair for hazard logic.
module hi_lo_multiply_divide_unit (
  input  logic                          clk,
  input  logic                          reset,
  hi_lo_multiply_divide_unit_if.slave   bus
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_count;
  logic        r_div0;
  logic        r_sign_a;
  logic        r_sign_b;

  // r_a holds the multiplicand, or the dividend shifting out as quotient shifts in
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;

  logic        w_valid_funct;
  logic        w_is_div;
  logic        w_is_signed;
  logic        w_accept;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quot;
  logic [31:0] w_remd;

  function automatic logic [31:0] f_abs32(input logic signed [31:0] v);
    logic signed [31:0] n;
    n = -v;
    return v[31] ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [31:0] f_neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign w_valid_funct = (bus.funct == F_MULT) || (bus.funct == F_MULTU) ||
                         (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign w_is_div      = bus.funct[1];
  assign w_is_signed   = ~bus.funct[0];
  assign w_accept      = (r_state == IDLE) && bus.start && w_valid_funct;

  assign w_shift    = {r_rem, r_a[31]};
  assign w_trial    = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_trial[32];
  assign w_rem_next = w_qbit ? w_trial[31:0] : w_shift[31:0];

  assign w_prod   = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod_s = (r_sign_a ^ r_sign_b) ? f_neg64(w_prod) : w_prod;

  // Truncation toward zero: remainder follows the dividend's sign
  assign w_quot = (r_sign_a ^ r_sign_b) ? f_neg32(r_a) : r_a;
  assign w_remd = r_sign_a ? f_neg32(r_rem) : r_rem;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_is_div)                  w_state_next = MULT;
          else if (bus.operand_B == 32'd0) w_state_next = FIX;
          else                             w_state_next = DIV;
        end
      end
      MULT:    w_state_next = IDLE;
      DIV:     if (r_count == 5'd31) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= 5'd0;
      r_div0   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= (r_state == MULT) || (r_state == FIX);
      if (w_accept) begin
        r_count  <= 5'd0;
        r_div0   <= w_is_div && (bus.operand_B == 32'd0);
        r_sign_a <= w_is_signed & bus.operand_A[31];
        r_sign_b <= w_is_signed & bus.operand_B[31];
      end else if (r_state == DIV) begin
        r_count <= r_count + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= w_is_signed ? f_abs32($signed(bus.operand_A)) : bus.operand_A;
      r_b   <= w_is_signed ? f_abs32($signed(bus.operand_B)) : bus.operand_B;
      r_rem <= 32'd0;
    end else if (r_state == DIV) begin
      r_rem <= w_rem_next;
      r_a   <= {r_a[30:0], w_qbit};
    end
  end

  // Direct writes only land when idle and no issue competes for the cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.start) begin
            if (bus.HI_register_write) r_hi <= bus.write_data;
            if (bus.LO_register_write) r_lo <= bus.write_data;
          end
        end
        MULT: {r_hi, r_lo} <= w_prod_s;
        FIX: begin
          if (!r_div0) begin
            r_lo <= w_quot;
            r_hi <= w_remd;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Directed bench for hi_lo_multiply_divide_unit: stimulus pushes expected
// {HI,LO} into a queue, a monitor pops and compares on every done pulse.
module tb_hi_lo_multiply_divide_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [63:0] sb_q[$];

  hi_lo_multiply_divide_unit_if bus ();

  hi_lo_multiply_divide_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("result_HI", bus.HI, e[63:32]);
        check("result_LO", bus.LO, e[31:0]);
      end
    end
  end

  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = f;
    bus.operand_A = a;
    bus.operand_B = b;
    if (push) sb_q.push_back({ehi, elo});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n0, input int ebusy);
    int n;
    n = n0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(ebusy));
    check({name, "_done"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic direct_write(input bit hi, input bit lo, input logic [31:0] d);
    @(negedge clk);
    bus.HI_register_write = hi;
    bus.LO_register_write = lo;
    bus.write_data        = d;
    @(negedge clk);
    bus.HI_register_write = 1'b0;
    bus.LO_register_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    n_checks = 0;
    n_fail   = 0;
    reset                 = 1'b1;
    bus.start             = 1'b0;
    bus.funct             = 6'd0;
    bus.operand_A         = 32'd0;
    bus.operand_B         = 32'd0;
    bus.HI_register_write = 1'b0;
    bus.LO_register_write = 1'b0;
    bus.write_data        = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_HI", bus.HI, 32'd0);
    check("reset_LO", bus.LO, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);

    start_op(F_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_done("mult_neg3x5", 0, 1);

    start_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    wait_done("multu_max", 0, 1);

    start_op(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_done("div_neg7_2", 0, 33);

    start_op(F_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_done("divu_100_7", 0, 33);

    start_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000);
    wait_done("div_min_m1", 0, 33);

    direct_write(1'b1, 1'b0, 32'h11);
    check("mthi", bus.HI, 32'h11);
    direct_write(1'b0, 1'b1, 32'h22);
    check("mtlo", bus.LO, 32'h22);
    check("mtlo_no_busy", {31'd0, bus.busy}, 32'd0);

    start_op(F_DIVU, 32'd55, 32'd0, 1'b1, 32'h11, 32'h22);
    wait_done("divu_by0", 0, 1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = 6'b100000;
    @(negedge clk);
    bus.start = 1'b0;
    check("bad_funct_busy", {31'd0, bus.busy}, 32'd0);
    check("bad_funct_done", {31'd0, bus.done}, 32'd0);

    start_op(F_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    bus.HI_register_write = 1'b1;
    bus.write_data        = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    bus.HI_register_write = 1'b0;
    bus.start     = 1'b1;
    bus.funct     = F_MULT;
    bus.operand_A = 32'd2;
    bus.operand_B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("mthi_while_busy", bus.HI, 32'h11);
    wait_done("divu_with_stray", 3, 33);

    start_op(F_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_HI", bus.HI, 32'd0);
    check("midrst_LO", bus.LO, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, saw_done}, 32'd0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
